// File: rtl/strobe_rx_fifo.sv
// Receive-side FIFO for the strobe crosser: captures data_in on each strobe pulse and
// presents it as a first-word-fall-through valid/ready stream with drop accounting.
module strobe_rx_fifo #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 4,
  parameter int CNT_W = 8
) (
  input  logic                     clk,
  input  logic                     reset_n,
  input  logic                     strobe_in,
  input  logic [WIDTH-1:0]         data_in,
  input  logic                     flush,
  output logic                     out_valid,
  input  logic                     out_ready,
  output logic [WIDTH-1:0]         out_data,
  output logic [$clog2(DEPTH):0]   level,
  output logic                     overflow,
  input  logic                     overflow_clr,
  output logic [CNT_W-1:0]         drop_count
);

  localparam int AW = $clog2(DEPTH);
  localparam int LW = AW + 1;

  logic [WIDTH-1:0] mem [DEPTH];

  logic [AW-1:0]    wr_ptr_q, wr_ptr_d;
  logic [AW-1:0]    rd_ptr_q, rd_ptr_d;
  logic [LW-1:0]    level_q, level_d;
  logic             overflow_q, overflow_d;
  logic [CNT_W-1:0] drop_cnt_q, drop_cnt_d;

  logic full;
  logic pop;
  logic push;
  logic drop;

  // Flush wins over every other action, so push/pop/drop are all masked by it.
  assign full = (level_q == LW'(DEPTH));
  assign pop  = (level_q != '0) && out_ready && !flush;
  assign push = strobe_in && !flush && (!full || pop);
  assign drop = strobe_in && !flush && full && !pop;

  always_comb begin
    wr_ptr_d   = wr_ptr_q;
    rd_ptr_d   = rd_ptr_q;
    level_d    = level_q;
    overflow_d = overflow_q;
    drop_cnt_d = drop_cnt_q;

    if (flush) begin
      wr_ptr_d = '0;
      rd_ptr_d = '0;
      level_d  = '0;
    end else begin
      if (push) wr_ptr_d = wr_ptr_q + AW'(1);
      if (pop)  rd_ptr_d = rd_ptr_q + AW'(1);
      level_d = level_q + LW'(push) - LW'(pop);
    end

    // A drop in the same cycle as a clear restarts the count at one.
    if (drop) begin
      overflow_d = 1'b1;
      if (overflow_clr)
        drop_cnt_d = CNT_W'(1);
      else if (drop_cnt_q != {CNT_W{1'b1}})
        drop_cnt_d = drop_cnt_q + CNT_W'(1);
    end else if (overflow_clr) begin
      overflow_d = 1'b0;
      drop_cnt_d = '0;
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      wr_ptr_q   <= '0;
      rd_ptr_q   <= '0;
      level_q    <= '0;
      overflow_q <= 1'b0;
      drop_cnt_q <= '0;
    end else begin
      wr_ptr_q   <= wr_ptr_d;
      rd_ptr_q   <= rd_ptr_d;
      level_q    <= level_d;
      overflow_q <= overflow_d;
      drop_cnt_q <= drop_cnt_d;
    end
  end

  // Storage carries no reset; contents are only meaningful below level.
  always_ff @(posedge clk) begin
    if (push) mem[wr_ptr_q] <= data_in;
  end

  assign out_valid  = (level_q != '0);
  assign out_data   = mem[rd_ptr_q];
  assign level      = level_q;
  assign overflow   = overflow_q;
  assign drop_count = drop_cnt_q;

endmodule
